// File: rtl/seq_cmp.sv
// seq_cmp: multi-cycle magnitude/equality comparator.
// Scans operands CHUNK bits per cycle, MSB chunk first, stopping early.
module seq_cmp #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             cmp_sign_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [1:0]       cmp_o
);

  localparam int CHK    = (CHUNK < 1) ? 1 : CHUNK;
  localparam int NCHUNK = WIDTH / CHK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  generate
    if (CHUNK < 1 || (WIDTH % CHK) != 0) begin : g_bad_cfg
      $error("seq_cmp: CHUNK must be >=1 and divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic              sign_q;
  logic [IW-1:0]     idx_q;
  logic [1:0]        cmp_q;

  logic [WIDTH-1:0]  a_m;
  logic [WIDTH-1:0]  b_m;
  logic [CHK-1:0]    a_c;
  logic [CHK-1:0]    b_c;
  logic              eq;
  logic [1:0]        cmp_d;

  // Flipping both MSBs maps signed order onto unsigned order.
  always_comb begin
    a_m = a_q;
    b_m = b_q;
    if (idx_q == LAST) begin
      a_m[WIDTH-1] = a_q[WIDTH-1] ^ sign_q;
      b_m[WIDTH-1] = b_q[WIDTH-1] ^ sign_q;
    end
    a_c = '0;
    b_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IW'(i)) begin
        a_c = a_m[i*CHK +: CHK];
        b_c = b_m[i*CHK +: CHK];
      end
    end
    eq    = (a_c == b_c);
    cmp_d = eq ? 2'b01 : {a_c < b_c, 1'b0};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= LAST;
      cmp_q   <= 2'b00;
      a_q     <= '0;
      b_q     <= '0;
      sign_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= IDLE;
      idx_q   <= LAST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            sign_q  <= cmp_sign_i;
            idx_q   <= LAST;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (!eq || idx_q == '0) begin
            cmp_q   <= cmp_d;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - IW'(1);
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign cmp_o       = cmp_q;

endmodule

// File: tb/tb_seq_cmp.sv
// tb_seq_cmp: directed and reference-model checks for seq_cmp
// (WIDTH=32, CHUNK=8).
module tb_seq_cmp;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  cmp;

  int nvec;
  int nerr;

  seq_cmp #(.WIDTH(32), .CHUNK(8)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .cmp_sign_i (sign),
    .a_i        (a),
    .b_i        (b),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .cmp_o      (cmp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Entered on a negedge with the DUT idle.
  task automatic run_op(input string tag,
                        input logic [31:0] av,
                        input logic [31:0] bv,
                        input logic sv,
                        input logic [1:0] ec,
                        input int elat,
                        input int hold);
    int lat;
    a = av;
    b = bv;
    sign = sv;
    in_valid = 1'b1;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) lat = c;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(elat));
    chk({tag, "_cmp"}, 32'(cmp), 32'(ec));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = ~av;
      b = 32'h0;
      sign = ~sv;
      @(negedge clk);
      chk({tag, "_hv"}, 32'(out_valid), 32'd1);
      chk({tag, "_hc"}, 32'(cmp), 32'(ec));
      chk({tag, "_hr"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
    chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
  endtask

  function automatic int nchk(input logic [31:0] av,
                              input logic [31:0] bv);
    for (int i = 3; i >= 0; i--)
      if (av[i*8 +: 8] != bv[i*8 +: 8]) return 4 - i;
    return 4;
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;
    logic [1:0]  ec;
    int          j;
    int          seen;
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    sign = 1'b0;
    a = '0;
    b = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_cmp", 32'(cmp), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("s_neg", 32'hFFFFFFFF, 32'h1, 1'b1, 2'b10, 2, 0);
    run_op("u_big", 32'hFFFFFFFF, 32'h1, 1'b0, 2'b00, 2, 0);
    run_op("eq", 32'h12345678, 32'h12345678, 1'b0, 2'b01, 5, 0);
    run_op("hold", 32'h100, 32'h101, 1'b1, 2'b10, 5, 3);
    run_op("s_pos", 32'h7FFFFFFF, 32'h80000000, 1'b1, 2'b00, 2, 0);
    run_op("u_mid", 32'h12005678, 32'h12FF5678, 1'b0, 2'b10, 3, 0);

    // Flush in cycle N+2, new operands accepted in N+3.
    a = 32'hA5A5A5A5;
    b = 32'hA5A5A5A5;
    sign = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fl_idle", 32'(in_ready), 32'd1);
    chk("fl_ov", 32'(out_valid), 32'd0);
    run_op("fl_new", 32'h5, 32'h3, 1'b0, 2'b00, 5, 0);

    // Flush beats in_valid in IDLE.
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_pri", 32'(in_ready), 32'd1);

    // Async reset mid-BUSY, checked before the next edge.
    a = 32'h01020304;
    b = 32'h01020304;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_busy", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("ar_rdy", 32'(in_ready), 32'd1);
    chk("ar_ov", 32'(out_valid), 32'd0);
    chk("ar_cmp", 32'(cmp), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    chk("ar_nores", 32'(seen), 32'd0);
    run_op("ar_acc", 32'h80000000, 32'h7FFFFFFF, 1'b1, 2'b10, 2, 0);

    // Reference model over randomized pairs sharing leading chunks.
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = ra;
      j = $urandom_range(0, 4);
      if (j < 4) rb[j*8 +: 8] = ra[j*8 +: 8] ^ 8'($urandom_range(1, 255));
      rs = 1'($urandom_range(0, 1));
      if (ra == rb) ec = 2'b01;
      else if (rs) ec = {$signed(ra) < $signed(rb), 1'b0};
      else ec = {ra < rb, 1'b0};
      run_op("rnd", ra, rb, rs, ec, 1 + nchk(ra, rb), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
